// File: rtl/alu_req_sched_if.sv
// Request/response bundle of alu_req_sched: two requesters on one side, the
// serial ALU link (sin/sout) and the response strobe on the other.
//
// Handshake: a requester raises its req_valid bit with operands stable and
// holds them until its req_ready bit has been high for one cycle (the grant);
// it may drop valid in the cycle after. rsp_valid is a one-cycle strobe with no
// back-pressure, and every rsp_* field reads zero whenever rsp_valid is low.
interface alu_req_sched_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [5:0]  req_op;
  logic        sin;
  logic        sout;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_c;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [5:0]  rsp_err_flags;
  logic        rsp_timeout;

  modport master (
    output req_valid, req_a, req_b, req_op, sout,
    input  req_ready, sin, rsp_valid, rsp_id, rsp_c, rsp_flags,
           rsp_err, rsp_err_flags, rsp_timeout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, sout,
    output req_ready, sin, rsp_valid, rsp_id, rsp_c, rsp_flags,
           rsp_err, rsp_err_flags, rsp_timeout
  );
endinterface

// File: rtl/alu_req_sched.sv
// Two-requester round-robin scheduler in front of a bit-serial ALU.
// Define ALU_SCHED_TIMEOUT_EN to add the response watchdog (rsp_timeout).
module alu_req_sched #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_req_sched_if.slave bus,
  output logic [2:0]     o_dbg_state
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RSP, RECV, DONE, GAP} state_t;

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_last;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [2:0]    r_op;
  logic [3:0]    r_crc;
  logic [3:0]    r_frame;
  logic [3:0]    r_bit;
  logic [8:0]    r_rx;
  logic [31:0]   r_c;
  logic [2:0]    r_dcnt;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rsp_c;
  logic [3:0]    r_rsp_flags;
  logic          r_rsp_err;
  logic [5:0]    r_rsp_err_flags;

  logic          w_any;
  logic          w_sel;
  logic [1:0]    w_grant;
  logic [31:0]   w_a;
  logic [31:0]   w_b;
  logic [2:0]    w_op;
  logic [7:0]    w_tx_byte;
  logic [2:0]    w_bidx;
  logic          w_sin;
  logic          w_rx_end;
  logic          w_tmo_hit;
  logic          w_done;

  // x^4+x+1, MSB first, zero seed
  function automatic logic [3:0] crc4(input logic [67:0] v);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ v[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  assign w_any   = |bus.req_valid;
  assign w_sel   = (&bus.req_valid) ? ~r_last : bus.req_valid[1];
  assign w_grant = (r_state == IDLE && w_any && rst_n) ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
  assign w_a     = w_sel ? bus.req_a[63:32] : bus.req_a[31:0];
  assign w_b     = w_sel ? bus.req_b[63:32] : bus.req_b[31:0];
  assign w_op    = w_sel ? bus.req_op[5:3]  : bus.req_op[2:0];
  assign w_bidx  = 3'(4'd9 - r_bit);

`ifdef ALU_SCHED_TIMEOUT_EN
  assign w_tmo_hit = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_tx_byte = 8'h00;
    case (r_frame)
      4'd0:    w_tx_byte = r_b[31:24];
      4'd1:    w_tx_byte = r_b[23:16];
      4'd2:    w_tx_byte = r_b[15:8];
      4'd3:    w_tx_byte = r_b[7:0];
      4'd4:    w_tx_byte = r_a[31:24];
      4'd5:    w_tx_byte = r_a[23:16];
      4'd6:    w_tx_byte = r_a[15:8];
      4'd7:    w_tx_byte = r_a[7:0];
      default: w_tx_byte = {1'b0, r_op, r_crc};
    endcase
  end

  // Reception ends on a control frame or on a broken stop bit.
  assign w_rx_end = (r_state == RECV) && (r_bit == 4'd10) && (!bus.sout || r_rx[8]);

  always_comb begin
    w_next = r_state;
    w_sin  = 1'b1;
    case (r_state)
      IDLE:     if (w_any) w_next = SEND;
      SEND: begin
        case (r_bit)
          4'd0:    w_sin = 1'b0;
          4'd1:    w_sin = (r_frame == 4'd8);
          4'd10:   w_sin = 1'b1;
          default: w_sin = w_tx_byte[w_bidx];
        endcase
        if (r_frame == 4'd8 && r_bit == 4'd10) w_next = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (!bus.sout)     w_next = RECV;
        else if (w_tmo_hit) w_next = DONE;
      end
      RECV: begin
        if (w_rx_end)       w_next = DONE;
        else if (w_tmo_hit) w_next = DONE;
      end
      DONE:     w_next = GAP;
      GAP:      if (r_cnt == CW'(GAP_CYCLES - 1)) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last          <= 1'b1;
      r_a             <= '0;
      r_b             <= '0;
      r_op            <= '0;
      r_crc           <= '0;
      r_frame         <= '0;
      r_bit           <= '0;
      r_rx            <= '0;
      r_c             <= '0;
      r_dcnt          <= '0;
      r_cnt           <= '0;
      r_rsp_c         <= '0;
      r_rsp_flags     <= '0;
      r_rsp_err       <= 1'b0;
      r_rsp_err_flags <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_last          <= w_sel;
          r_a             <= w_a;
          r_b             <= w_b;
          r_op            <= w_op;
          r_crc           <= crc4({w_b, w_a, 1'b1, w_op});
          r_frame         <= '0;
          r_bit           <= '0;
          r_c             <= '0;
          r_dcnt          <= '0;
          r_rsp_c         <= '0;
          r_rsp_flags     <= '0;
          r_rsp_err       <= 1'b0;
          r_rsp_err_flags <= '0;
        end
        SEND: begin
          if (r_bit == 4'd10) begin
            r_bit   <= '0;
            r_frame <= r_frame + 4'd1;
          end else begin
            r_bit <= r_bit + 4'd1;
          end
        end
        WAIT_RSP: if (!bus.sout) r_bit <= 4'd1;
        RECV: begin
          if (r_bit == 4'd0) begin
            if (!bus.sout) r_bit <= 4'd1;
          end else if (r_bit != 4'd10) begin
            r_rx  <= {r_rx[7:0], bus.sout};
            r_bit <= r_bit + 4'd1;
          end else begin
            // r_rx = {type, payload[7:0]}; sout is the stop bit
            r_bit <= '0;
            if (!bus.sout) begin
              r_rsp_err <= 1'b1;
            end else if (!r_rx[8]) begin
              r_c <= {r_c[23:0], r_rx[7:0]};
              if (r_dcnt != 3'd4) r_dcnt <= r_dcnt + 3'd1;
            end else if (r_rx[7]) begin
              r_rsp_err       <= 1'b1;
              r_rsp_err_flags <= r_rx[6:1];
            end else if (r_dcnt < 3'd4) begin
              r_rsp_err <= 1'b1;
            end else begin
              r_rsp_c     <= r_c;
              r_rsp_flags <= r_rx[6:3];
            end
          end
        end
        DONE:    r_cnt <= '0;
        GAP:     r_cnt <= r_cnt + 1'b1;
        default: ;
      endcase
`ifdef ALU_SCHED_TIMEOUT_EN
      // Watchdog counts cycles elapsed since the final stop bit went out.
      if (r_state == SEND && w_next == WAIT_RSP)
        r_cnt <= CW'(1);
      else if (r_state == WAIT_RSP || r_state == RECV)
        r_cnt <= r_cnt + 1'b1;
`endif
    end
  end

`ifdef ALU_SCHED_TIMEOUT_EN
  logic r_rsp_to;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rsp_to <= 1'b0;
    else if (r_state == IDLE && w_any)
      r_rsp_to <= 1'b0;
    else if ((r_state == WAIT_RSP || r_state == RECV) && w_next == DONE && !w_rx_end)
      r_rsp_to <= 1'b1;
  end
`endif

  assign w_done            = (r_state == DONE);
  assign bus.req_ready     = w_grant;
  assign bus.sin           = w_sin;
  assign bus.rsp_valid     = w_done;
  assign bus.rsp_id        = w_done & r_last;
  assign bus.rsp_c         = w_done ? r_rsp_c : '0;
  assign bus.rsp_flags     = w_done ? r_rsp_flags : '0;
  assign bus.rsp_err       = w_done & r_rsp_err;
  assign bus.rsp_err_flags = w_done ? r_rsp_err_flags : '0;
`ifdef ALU_SCHED_TIMEOUT_EN
  assign bus.rsp_timeout   = w_done & r_rsp_to;
`else
  assign bus.rsp_timeout   = 1'b0;
`endif
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_alu_req_sched.sv
// Directed bench for alu_req_sched: bit-exact check of the transmitted frames,
// an ALU reply model on sout and a scoreboard of expected responses.
module tb_alu_req_sched;
  localparam int TMO = 128;
  localparam int GAP = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  alu_req_sched_if bus ();

  alu_req_sched #(.TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [44:0] exp_q[$];
  logic [2:0]  op_tab [4] = '{3'b000, 3'b001, 3'b100, 3'b101};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [44:0] pk(input logic id, input logic [31:0] c, input logic [3:0] fl,
                                     input logic err, input logic [5:0] ef, input logic to);
    return {id, c, fl, err, ef, to};
  endfunction

  function automatic logic [44:0] obs_rsp();
    return {bus.rsp_id, bus.rsp_c, bus.rsp_flags, bus.rsp_err, bus.rsp_err_flags, bus.rsp_timeout};
  endfunction

  // Remainder of M(x)*x^4 divided by x^4+x+1
  function automatic logic [3:0] crc_model(input logic [67:0] m);
    logic [71:0] v;
    v = {m, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
    return v[3:0];
  endfunction

  function automatic logic [98:0] tx_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [7:0]  pay [9];
    logic [98:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      pay[k]     = b[31 - 8*k -: 8];
      pay[k + 4] = a[31 - 8*k -: 8];
    end
    pay[8] = {1'b0, op, crc_model({b, a, 1'b1, op})};
    for (int f = 0; f < 9; f++)
      v = {v[87:0], 1'b0, (f == 8), pay[f], 1'b1};
    return v;
  endfunction

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b100:  return a + b;
      default: return a - b;
    endcase
  endfunction

  task automatic drive_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bus.req_a[32*id +: 32] = a;
    bus.req_b[32*id +: 32] = b;
    bus.req_op[3*id +: 3]  = op;
    bus.req_valid[id]      = 1'b1;
  endtask

  task automatic wait_grant(input logic [1:0] exp, input string tag, output int cyc);
    cyc = 0;
    #1;
    while (bus.req_ready == 2'b00 && cyc < 400) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (bus.req_ready == 2'b00) check({tag, "_wait_expired"}, 0, 1);
    else                        check(tag, bus.req_ready, exp);
  endtask

  task automatic capture_tx(input int id, input int nbits, output logic [98:0] cap, output logic busy_rdy);
    cap = '0;
    busy_rdy = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (i == 0) bus.req_valid[id] = 1'b0;
      cap = {cap[97:0], bus.sin};
      busy_rdy = busy_rdy | (|bus.req_ready);
    end
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] pay, input logic stop);
    logic [10:0] f;
    f = {1'b0, typ, pay, stop};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      bus.sout = f[i];
    end
  endtask

  task automatic send_data(input int n, input logic [31:0] c);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(2)) begin
        @(negedge clk);
        bus.sout = 1'b1;
      end
      send_frame(1'b0, c[31 - 8*k -: 8], 1'b1);
    end
  endtask

  task automatic wait_rsp(input string tag, input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      bus.sout = 1'b1;
      cyc++;
      if (bus.rsp_valid) break;
    end
    if (!bus.rsp_valid)          check({tag, "_rsp_wait_expired"}, 0, 1);
    else if (exp_q.size() == 0)  check({tag, "_unexpected_rsp"}, 0, 1);
    else                         check({tag, "_rsp"}, obs_rsp(), exp_q.pop_front());
    @(negedge clk);
    check({tag, "_rsp_pulse"}, {bus.rsp_valid, obs_rsp()}, 0);
  endtask

  // kind: 0 normal reply, 1 error frame, 2 short reply, 3 broken stop bit
  task automatic do_txn(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input int kind, input string tag, output int gcyc);
    logic [98:0] cap;
    logic        busy_rdy;
    logic [31:0] c;
    logic [3:0]  fl;
    int          rc;
    drive_req(id, a, b, op);
    wait_grant((id == 0) ? 2'b01 : 2'b10, {tag, "_grant"}, gcyc);
    capture_tx(id, 99, cap, busy_rdy);
    check({tag, "_sin"}, cap, tx_model(a, b, op));
    check({tag, "_ready_busy"}, busy_rdy, 0);
    check({tag, "_rsp_idle"}, {bus.rsp_valid, obs_rsp()}, 0);
    c  = alu_model(op, a, b);
    fl = {c == 32'h0, c[31], 2'b01};
    case (kind)
      0: begin
        exp_q.push_back(pk(id[0], c, fl, 1'b0, 6'h00, 1'b0));
        send_data(4, c);
        send_frame(1'b1, {1'b0, fl, 3'b000}, 1'b1);
      end
      1: begin
        exp_q.push_back(pk(id[0], 32'h0, 4'h0, 1'b1, 6'b010000, 1'b0));
        send_frame(1'b1, 8'b1_010000_1, 1'b1);
      end
      2: begin
        exp_q.push_back(pk(id[0], 32'h0, 4'h0, 1'b1, 6'h00, 1'b0));
        send_data(2, c);
        send_frame(1'b1, {1'b0, fl, 3'b000}, 1'b1);
      end
      default: begin
        exp_q.push_back(pk(id[0], 32'h0, 4'h0, 1'b1, 6'h00, 1'b0));
        send_frame(1'b0, c[31:24], 1'b0);
      end
    endcase
    wait_rsp(tag, 40, rc);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int          g;
    int          rc;
    logic [98:0] cap;
    logic        busy_rdy;

    bus.req_valid = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.sout      = 1'b1;

    // Reset with both requesters already pending
    drive_req(0, 32'h1, 32'h2, 3'b100);
    drive_req(1, 32'hFFFF_FFFF, 32'h0, 3'b000);
    #12;
    check("rst_ready", bus.req_ready, 0);
    check("rst_sin", bus.sin, 1);
    check("rst_rsp", {bus.rsp_valid, obs_rsp()}, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contended start: requester 0 first, requester 1 after the gap
    do_txn(0, 32'h1, 32'h2, 3'b100, 0, "add_r0", g);
    check("first_grant_latency", g, 0);
    do_txn(1, 32'hFFFF_FFFF, 32'h0, 3'b000, 0, "and_r1", g);
    check("gap_cycles", g, GAP);

    for (int i = 0; i < 4; i++)
      do_txn(i % 2, $urandom, $urandom, op_tab[$urandom_range(3)], 0, "rand", g);

    do_txn(1, 32'h1234_5678, 32'h0F0F_0F0F, 3'b001, 1, "err_frame", g);
    do_txn(0, 32'hA5A5_0000, 32'h0000_5A5A, 3'b101, 2, "short_rsp", g);
    do_txn(1, 32'h7, 32'h9, 3'b100, 3, "bad_stop", g);

    // Reset while bit 40 of the request is on the line
    drive_req(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b101);
    wait_grant(2'b01, "mid_rst_grant", g);
    capture_tx(0, 40, cap, busy_rdy);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sin", bus.sin, 1);
    check("mid_rst_ready", bus.req_ready, 0);
    check("mid_rst_rsp", {bus.rsp_valid, obs_rsp()}, 0);
    check("mid_rst_state", dbg_state, 0);
    @(negedge clk);
    drive_req(1, 32'h55, 32'h66, 3'b000);
    rst_n = 1'b1;
    do_txn(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b101, 0, "post_rst_r0", g);
    do_txn(1, 32'h55, 32'h66, 3'b000, 0, "post_rst_r1", g);

    // Silent ALU
    drive_req(0, 32'h3, 32'h4, 3'b100);
    wait_grant(2'b01, "silent_grant", g);
    capture_tx(0, 99, cap, busy_rdy);
    check("silent_sin", cap, tx_model(32'h3, 32'h4, 3'b100));
`ifdef ALU_SCHED_TIMEOUT_EN
    exp_q.push_back(pk(1'b0, 32'h0, 4'h0, 1'b0, 6'h00, 1'b1));
    wait_rsp("watchdog", TMO + 20, rc);
    check("watchdog_latency", rc, TMO);
`else
    rc = 0;
    for (int i = 0; i < 2 * TMO; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.rsp_timeout) rc++;
    end
    check("no_watchdog_rsp", rc, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
